hazard_ctrl: RTL and testbench

//   Pipeline hazard controller for the decode->execute boundary. Watches the decoded

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode->execute hazard controller: load-use stalls, EX forwarding selects,
// branch flush sequencing and saturating stall/flush counters.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif

module hazard_ctrl #(
    parameter int AWIDTH    = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     h_clk,
    input  logic                     h_rst,
    input  logic                     h_i_ce,
    input  logic [`OPCODE_WIDTH-1:0] h_i_opcode,
    input  logic [AWIDTH-1:0]        h_i_addr_rs,
    input  logic [AWIDTH-1:0]        h_i_addr_rt,
    input  logic [AWIDTH-1:0]        h_i_addr_rd,
    input  logic                     h_i_br_taken,
    output logic                     h_o_stall,
    output logic                     h_o_flush,
    output logic                     h_o_ex_ce,
    output logic [1:0]               h_o_fwd_rs,
    output logic [1:0]               h_o_fwd_rt,
    output logic [CNT_WIDTH-1:0]     h_o_stall_cnt,
    output logic [CNT_WIDTH-1:0]     h_o_flush_cnt
);

    localparam int OW = `OPCODE_WIDTH;
    localparam logic [OW-1:0] OP_RTYPE  = OW'(0);
    localparam logic [OW-1:0] OP_LOAD   = OW'(35);
    localparam logic [OW-1:0] OP_STORE  = OW'(43);
    localparam logic [OW-1:0] OP_BRANCH = OW'(4);

    typedef enum logic [1:0] {RUN, FLUSH1, FLUSH2} state_t;

    typedef struct packed {
        logic              v;
        logic [AWIDTH-1:0] dst;
        logic              ld;
    } slot_t;

    state_t                state_q, state_d;
    slot_t                 ex_q, ex_d, mem_q, mem_d;
    logic                  flush_q, flush_d;
    logic                  ex_ce_q, ex_ce_d;
    logic [1:0]            fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    logic              use_rs, use_rt, is_ld, dst_v, run;
    logic              hit_rs, hit_rt, stall, accept;
    logic [AWIDTH-1:0] dst;

    function automatic logic [1:0] fwd_sel(input logic [AWIDTH-1:0] src,
                                           input logic              used,
                                           input slot_t             ex,
                                           input slot_t             mem);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != '0) begin
            if (ex.v && ex.dst == src)        sel = 2'b01;
            else if (mem.v && mem.dst == src) sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_ld  = 1'b0;
        dst_v  = 1'b0;
        dst    = '0;
        case (h_i_opcode)
            OP_RTYPE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dst_v  = 1'b1;
                dst    = h_i_addr_rd;
            end
            OP_LOAD: begin
                use_rs = 1'b1;
                is_ld  = 1'b1;
                dst_v  = 1'b1;
                dst    = h_i_addr_rt;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        run    = (state_q == RUN);
        hit_rs = use_rs && h_i_addr_rs != '0 && h_i_addr_rs == ex_q.dst;
        hit_rt = use_rt && h_i_addr_rt != '0 && h_i_addr_rt == ex_q.dst;
        // Branch squash outranks the load-use check.
        stall  = run && !h_i_br_taken && h_i_ce && ex_q.v && ex_q.ld
                 && (hit_rs || hit_rt);
        accept = run && !h_i_br_taken && h_i_ce && !stall;

        state_d = state_q;
        case (state_q)
            RUN:     if (h_i_br_taken) state_d = FLUSH1;
            FLUSH1:  state_d = FLUSH2;
            FLUSH2:  state_d = RUN;
            default: state_d = RUN;
        endcase

        mem_d = ex_q;
        ex_d  = '0;
        if (accept) begin
            ex_d.v   = dst_v && dst != '0;
            ex_d.dst = dst_v ? dst : '0;
            ex_d.ld  = is_ld;
        end

        ex_ce_d  = accept;
        flush_d  = (state_d != RUN);
        fwd_rs_d = accept ? fwd_sel(h_i_addr_rs, use_rs, ex_q, mem_q) : 2'b00;
        fwd_rt_d = accept ? fwd_sel(h_i_addr_rt, use_rt, ex_q, mem_q) : 2'b00;

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_d && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            flush_q     <= 1'b0;
            ex_ce_q     <= 1'b0;
            fwd_rs_q    <= 2'b00;
            fwd_rt_q    <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            flush_q     <= flush_d;
            ex_ce_q     <= ex_ce_d;
            fwd_rs_q    <= fwd_rs_d;
            fwd_rt_q    <= fwd_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign h_o_stall     = stall;
    assign h_o_flush     = flush_q;
    assign h_o_ex_ce     = ex_ce_q;
    assign h_o_fwd_rs    = fwd_rs_q;
    assign h_o_fwd_rt    = fwd_rt_q;
    assign h_o_stall_cnt = stall_cnt_q;
    assign h_o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// traffic against a pipeline-history reference model.
module tb_hazard_ctrl;

    localparam int CW = 3;
    localparam int SAT = (1 << CW) - 1;
    localparam logic [5:0] R  = 6'h00;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;
    localparam logic [5:0] BQ = 6'h04;
    localparam logic [5:0] AI = 6'h08;

    logic          h_clk = 1'b0;
    logic          h_rst = 1'b0;
    logic          h_i_ce = 1'b0;
    logic [5:0]    h_i_opcode = '0;
    logic [4:0]    h_i_addr_rs = '0, h_i_addr_rt = '0, h_i_addr_rd = '0;
    logic          h_i_br_taken = 1'b0;
    logic          h_o_stall, h_o_flush, h_o_ex_ce;
    logic [1:0]    h_o_fwd_rs, h_o_fwd_rt;
    logic [CW-1:0] h_o_stall_cnt, h_o_flush_cnt;

    hazard_ctrl #(.AWIDTH(5), .CNT_WIDTH(CW)) dut (
        .h_clk(h_clk), .h_rst(h_rst), .h_i_ce(h_i_ce),
        .h_i_opcode(h_i_opcode), .h_i_addr_rs(h_i_addr_rs),
        .h_i_addr_rt(h_i_addr_rt), .h_i_addr_rd(h_i_addr_rd),
        .h_i_br_taken(h_i_br_taken), .h_o_stall(h_o_stall),
        .h_o_flush(h_o_flush), .h_o_ex_ce(h_o_ex_ce),
        .h_o_fwd_rs(h_o_fwd_rs), .h_o_fwd_rt(h_o_fwd_rt),
        .h_o_stall_cnt(h_o_stall_cnt), .h_o_flush_cnt(h_o_flush_cnt));

    always #5 h_clk = ~h_clk;

    typedef struct {bit v; int dst; bit ld;} ent_t;

    ent_t pipe[2];
    int   m_fl, m_sc, m_fc, m_frs, m_frt, m_exce, m_stall;
    int   n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit uses_rs(input logic [5:0] op);
        return op == R || op == LW || op == SW || op == BQ;
    endfunction

    function automatic bit uses_rt(input logic [5:0] op);
        return op == R || op == SW || op == BQ;
    endfunction

    function automatic int dest(input logic [5:0] op, input int rt, input int rd);
        if (op == R)  return rd;
        if (op == LW) return rt;
        return 0;
    endfunction

    function automatic int fsel(input bit used, input int src);
        if (!used || src == 0) return 0;
        if (pipe[0].v && pipe[0].dst == src) return 1;
        if (pipe[1].v && pipe[1].dst == src) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        pipe[0] = '{0, 0, 0};
        pipe[1] = '{0, 0, 0};
        m_fl = 0; m_sc = 0; m_fc = 0;
        m_frs = 0; m_frt = 0; m_exce = 0;
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, "_flush"}, 32'(h_o_flush), 32'(m_fl > 0));
        chk({pfx, "_ex_ce"}, 32'(h_o_ex_ce), 32'(m_exce));
        chk({pfx, "_fwd_rs"}, 32'(h_o_fwd_rs), 32'(m_frs));
        chk({pfx, "_fwd_rt"}, 32'(h_o_fwd_rt), 32'(m_frt));
        chk({pfx, "_stall_cnt"}, 32'(h_o_stall_cnt), 32'(m_sc));
        chk({pfx, "_flush_cnt"}, 32'(h_o_flush_cnt), 32'(m_fc));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string pfx, input bit ce, input logic [5:0] op,
                        input int rs, input int rt, input int rd, input bit br);
        bit hz, acc;
        int d;
        h_i_ce = ce; h_i_opcode = op; h_i_br_taken = br;
        h_i_addr_rs = 5'(rs); h_i_addr_rt = 5'(rt); h_i_addr_rd = 5'(rd);
        hz = pipe[0].v && pipe[0].ld &&
             ((uses_rs(op) && rs != 0 && rs == pipe[0].dst) ||
              (uses_rt(op) && rt != 0 && rt == pipe[0].dst));
        m_stall = int'(m_fl == 0 && !br && ce && hz);
        #1;
        chk({pfx, "_stall"}, 32'(h_o_stall), 32'(m_stall));
        @(posedge h_clk);
        acc = m_fl == 0 && !br && ce && m_stall == 0;
        m_exce = int'(acc);
        m_frs = acc ? fsel(uses_rs(op), rs) : 0;
        m_frt = acc ? fsel(uses_rt(op), rt) : 0;
        if (m_fl > 0) m_fl--;
        else if (br) m_fl = 2;
        if (m_stall != 0) m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
        if (m_fl > 0)     m_fc = (m_fc + 1 > SAT) ? SAT : m_fc + 1;
        d = dest(op, rt, rd);
        pipe[1] = pipe[0];
        pipe[0] = '{acc && d != 0, acc ? d : 0, acc && op == LW};
        #1;
        chk_regs(pfx);
        @(negedge h_clk);
    endtask

    task automatic reset_now(input string pfx);
        #2 h_rst = 1'b0;
        #1;
        model_reset();
        chk({pfx, "_stall"}, 32'(h_o_stall), 32'd0);
        chk_regs(pfx);
        @(negedge h_clk);
        h_rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge h_clk);
        chk("rst_stall", 32'(h_o_stall), 32'd0);
        chk_regs("rst");
        h_rst = 1'b1;
        @(negedge h_clk);

        step("t1a", 1, R, 1, 2, 3, 0);
        step("t1b", 1, R, 3, 5, 4, 0);
        chk("t1_fwd_rs", 32'(h_o_fwd_rs), 32'd1);

        step("t2a", 1, R, 1, 2, 3, 0);
        step("t2b", 1, R, 0, 0, 0, 0);
        step("t2c", 1, R, 7, 3, 6, 0);
        chk("t2_fwd_rt", 32'(h_o_fwd_rt), 32'd2);
        chk("t2_fwd_rs", 32'(h_o_fwd_rs), 32'd0);

        step("t3a", 1, LW, 1, 8, 0, 0);
        step("t3b", 1, R, 8, 8, 9, 0);
        chk("t3_bubble", 32'(h_o_ex_ce), 32'd0);
        step("t3c", 1, R, 8, 8, 9, 0);
        chk("t3_fwd_rs", 32'(h_o_fwd_rs), 32'd2);
        chk("t3_fwd_rt", 32'(h_o_fwd_rt), 32'd2);
        chk("t3_stall_cnt", 32'(h_o_stall_cnt), 32'd1);

        step("t4a", 1, R, 1, 2, 0, 0);
        step("t4b", 1, R, 0, 0, 1, 0);
        chk("t4_fwd_rs", 32'(h_o_fwd_rs), 32'd0);
        step("t4c", 1, LW, 1, 0, 0, 0);
        step("t4d", 1, R, 0, 0, 1, 0);

        step("t5a", 1, LW, 1, 8, 0, 0);
        step("t5b", 1, R, 8, 8, 9, 1);
        step("t5c", 1, R, 8, 8, 9, 0);
        step("t5d", 1, R, 8, 8, 9, 0);
        chk("t5_flush_cnt", 32'(h_o_flush_cnt), 32'd2);
        chk("t5_flush_done", 32'(h_o_flush), 32'd0);
        step("t5e", 1, R, 8, 8, 9, 0);
        chk("t5_run", 32'(h_o_ex_ce), 32'd1);

        step("t6a", 1, LW, 1, 8, 0, 0);
        h_i_opcode = R; h_i_addr_rs = 5'd8; h_i_addr_rt = 5'd8;
        h_i_addr_rd = 5'd9; h_i_ce = 1'b1;
        #1 chk("t6_pre_stall", 32'(h_o_stall), 32'd1);
        reset_now("t6r1");
        step("t6b", 1, R, 8, 8, 9, 0);
        chk("t6_fwd_after", 32'(h_o_fwd_rs), 32'd0);
        step("t6c", 1, R, 1, 2, 3, 1);
        reset_now("t6r2");
        step("t6d", 1, R, 3, 3, 4, 0);
        chk("t6_ex_ce", 32'(h_o_ex_ce), 32'd1);

        for (int i = 0; i < 9; i++) begin
            step("sat_lw", 1, LW, 2, 10, 0, 0);
            step("sat_st", 1, SW, 3, 10, 0, 0);
            step("sat_go", 1, SW, 3, 10, 0, 0);
        end
        chk("sat_stall", 32'(h_o_stall_cnt), 32'(SAT));
        for (int i = 0; i < 5; i++) begin
            step("sat_br", 1, R, 1, 2, 3, 1);
            step("sat_f1", 1, R, 1, 2, 3, 0);
            step("sat_f2", 1, R, 1, 2, 3, 0);
        end
        chk("sat_flush", 32'(h_o_flush_cnt), 32'(SAT));

        reset_now("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            int k;
            k = int'($urandom_range(0, 5));
            op = (k == 0) ? AI : (k == 1) ? SW : (k == 2) ? BQ :
                 (k == 3) ? LW : R;
            step("rnd", ($urandom % 4) != 0, op,
                 int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
                 m_fl == 0 && ($urandom % 12) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
